// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I pipeline memory path.
//   - funct3 encodings for load/store access size and sign
//   - ResultSrc encodings used by the writeback mux
//   - mem_wb_t: the MEM/WB pipeline register payload
//   - access_fault(): misaligned / illegal load-store detection
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic        misalign;
  } mem_wb_t;

  // Flags an access that must not touch memory or the register file.
  // Unsigned sizes only exist for loads, so BU/HU on a store is illegal.
  // Instructions that are neither a load nor a store never fault.
  function automatic logic access_fault(input logic [2:0] f3,
                                        input logic [1:0] lane,
                                        input logic       is_load,
                                        input logic       is_store);
    logic illegal;
    logic unaligned;
    illegal   = 1'b0;
    unaligned = 1'b0;
    case (f3)
      F3_B:  begin
        illegal   = 1'b0;
        unaligned = 1'b0;
      end
      F3_H:  unaligned = lane[0];
      F3_W:  unaligned = |lane;
      F3_BU: illegal = is_store;
      F3_HU: begin
        illegal   = is_store;
        unaligned = lane[0];
      end
      default: illegal = 1'b1;
    endcase
    return (is_load | is_store) & (illegal | unaligned);
  endfunction

endpackage

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// 2^DEPTH_LOG2 x 32-bit data RAM, byte-enable synchronous write and
// asynchronous (combinational) read. Contents are not reset.
// Ports:
//   clk      in  1           rising-edge clock
//   i_we     in  1           write enable (already qualified by the caller)
//   i_be     in  4           byte enables, bit n writes byte lane n
//   i_addr   in  DEPTH_LOG2  word index
//   i_wdata  in  32          lane-replicated write data
//   o_rdata  out 32          word at i_addr
// ---------------------------------------------------------------------------
module data_memory #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
// RV32I MEM stage plus MEM/WB pipeline register. Performs loads/stores
// against a local data RAM, extends load data per funct3 and registers the
// W-stage signals for the writeback mux.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   RegWriteM, MemWriteM   M-stage control: writes rd / is a store
//   ResultSrcM[1:0]        00 ALU, 01 memory (load), 10 PC+4
//   funct3M[2:0]           access size and sign
//   ALUResultM[31:0]       effective address or ALU result
//   WriteDataM[31:0]       low-aligned store data
//   PCPlus4M[31:0]         return address
//   RdM[4:0]               destination register
//   StallW, FlushW         hold / bubble the MEM/WB register
//   RegWriteW .. MisalignW registered W-stage outputs
//
// Pipeline control: each edge the MEM/WB register clears on rst, else
// clears on FlushW (bubble), else holds on StallW, else loads the M values.
// A store only commits on an edge where the M instruction actually advances
// (no rst, no flush, no stall), so a stalled store writes exactly once.
// ---------------------------------------------------------------------------
module memory_stage
  import riscv_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic        StallW,
  input  logic        FlushW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        MisalignW
);

  logic [1:0]            w_lane;
  logic [DEPTH_LOG2-1:0] w_word;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_misalign;
  logic                  w_we;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_ext;
  mem_wb_t               w_next;
  mem_wb_t               r_w;

  // Upper address bits are dropped, so addresses alias modulo RAM size.
  assign w_lane     = ALUResultM[1:0];
  assign w_word     = ALUResultM[DEPTH_LOG2+1:2];
  assign w_is_load  = (ResultSrcM == RS_MEM);
  assign w_is_store = MemWriteM;
  assign w_misalign = access_fault(funct3M, w_lane, w_is_load, w_is_store);

  assign w_we = w_is_store & ~w_misalign & ~StallW & ~FlushW & ~rst;

  // Store lane steering: data is replicated across lanes so only the
  // byte enables need to depend on the address.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WriteDataM;
    case (funct3M)
      F3_B: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      F3_H: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      F3_W: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
      end
    endcase
  end

  data_memory #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_data_memory (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_word),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Load lane selection and extension, done before the MEM/WB register.
  always_comb begin
    w_byte = 8'h00;
    case (w_lane)
      2'd0:    w_byte = w_rdata[7:0];
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      default: w_byte = w_rdata[31:24];
    endcase
    w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

    w_ext = 32'h0000_0000;
    case (funct3M)
      F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_ext = {24'h00_0000, w_byte};
      F3_H:    w_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   w_ext = {16'h0000, w_half};
      F3_W:    w_ext = w_rdata;
      default: w_ext = 32'h0000_0000;
    endcase
  end

  always_comb begin
    w_next            = '0;
    w_next.reg_write  = RegWriteM & ~w_misalign;
    w_next.result_src = ResultSrcM;
    w_next.alu_result = ALUResultM;
    // Faulting and non-load instructions carry zero load data.
    w_next.read_data  = (w_is_load & ~w_misalign) ? w_ext : 32'h0000_0000;
    w_next.pc_plus4   = PCPlus4M;
    w_next.rd         = RdM;
    w_next.misalign   = w_misalign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w <= '0;
    end else if (FlushW) begin
      r_w <= '0;
    end else if (!StallW) begin
      r_w <= w_next;
    end
  end

  assign RegWriteW  = r_w.reg_write;
  assign ResultSrcW = r_w.result_src;
  assign ALUResultW = r_w.alu_result;
  assign ReadDataW  = r_w.read_data;
  assign PCPlus4W   = r_w.pc_plus4;
  assign RdW        = r_w.rd;
  assign MisalignW  = r_w.misalign;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
// Scoreboarded bench for memory_stage: the driver pushes the expected W
// state for every cycle into exp_q, a negedge monitor pops and compares.
// The reference model is a flat byte array addressed modulo RAM size.
// ---------------------------------------------------------------------------
module tb_memory_stage;
  import riscv_pkg::*;

  localparam int DEPTH_LOG2 = 8;
  localparam int MEM_BYTES  = 4 * (2**DEPTH_LOG2);

  typedef struct packed {
    logic        chk_rd;
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallW, FlushW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        MisalignW;

  memory_stage #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RdM        (RdM),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW),
    .MisalignW  (MisalignW)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       mem_model [MEM_BYTES];
  exp_t             last_exp;
  int               n_checks;
  int               n_fail;
  logic [31:0]      pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_fault(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic is_load, input logic is_store);
    logic ld_ok, st_ok;
    ld_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    st_ok = (f3 <= 3'd2);
    if (!is_load && !is_store) return 1'b0;
    if (is_load && !ld_ok) return 1'b1;
    if (is_store && !st_ok) return 1'b1;
    return (addr % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int          sz;
    int unsigned a;
    sz = acc_size(f3);
    a  = addr % MEM_BYTES;
    v  = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(mem_model[(a + i) % MEM_BYTES]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  // ---------------- driver ----------------
  // Applies one M-stage instruction for one cycle, pushes the expected W
  // state that follows the next rising edge, and updates the model memory.
  task automatic drive(input logic r, input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic stall, input logic flush);
    exp_t        nx;
    exp_t        e;
    logic        is_load;
    logic        mis;
    int unsigned a;
    rst        = r;
    RegWriteM  = rw;
    MemWriteM  = mw;
    ResultSrcM = rs;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    PCPlus4M   = pc;
    RdM        = rd;
    StallW     = stall;
    FlushW     = flush;

    is_load  = (rs == RS_MEM);
    mis      = model_fault(f3, addr, is_load, mw);
    nx.chk_rd = is_load || mis;
    nx.rw     = rw && !mis;
    nx.rs     = rs;
    nx.alu    = addr;
    nx.rdata  = (is_load && !mis) ? model_read(f3, addr) : 32'h0;
    nx.pc4    = pc;
    nx.rd     = rd;
    nx.mis    = mis;

    if (r || flush) begin
      e = '0;
      e.chk_rd = 1'b1;
    end else if (stall) begin
      e = last_exp;
    end else begin
      e = nx;
    end
    last_exp = e;
    exp_q.push_back(EXP_W'(e));

    if (mw && !mis && !stall && !flush && !r) begin
      a = addr % MEM_BYTES;
      for (int i = 0; i < acc_size(f3); i++) mem_model[(a + i) % MEM_BYTES] = 8'(wd >> (8 * i));
    end

    pc = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    drive(1'b0, 1'b0, 1'b1, RS_ALU, f3, addr, wd, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    drive(1'b0, 1'b1, 1'b0, RS_MEM, f3, addr, 32'h0, rd, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("RegWriteW",  {31'h0, RegWriteW},  {31'h0, e.rw});
      chk("ResultSrcW", {30'h0, ResultSrcW}, {30'h0, e.rs});
      chk("ALUResultW", ALUResultW, e.alu);
      chk("PCPlus4W",   PCPlus4W, e.pc4);
      chk("RdW",        {27'h0, RdW}, {27'h0, e.rd});
      chk("MisalignW",  {31'h0, MisalignW}, {31'h0, e.mis});
      if (e.chk_rd) chk("ReadDataW", ReadDataW, e.rdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    pc       = 32'h0000_1000;
    last_exp = '0;
    for (int i = 0; i < MEM_BYTES; i++) mem_model[i] = 8'h00;

    drive(1'b1, 1'b1, 1'b0, RS_ALU, F3_W, 32'h1234_5678, 32'h0, 5'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, RS_ALU, F3_W, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("reset_regwrite", {31'h0, RegWriteW}, 32'h0);
    chk("reset_alu", ALUResultW, 32'h0);

    // Bring RAM and model into a known state.
    for (int w = 0; w < 2**DEPTH_LOG2; w++) do_store(F3_W, 32'(w * 4), $urandom);

    do_store(F3_W, 32'h10, 32'hDEAD_BEEF);
    do_load(F3_W, 32'h10, 5'd5);
    chk("lw_deadbeef", ReadDataW, 32'hDEAD_BEEF);
    chk("lw_resultsrc", {30'h0, ResultSrcW}, 32'h1);
    chk("lw_regwrite", {31'h0, RegWriteW}, 32'h1);
    do_load(F3_B, 32'h13, 5'd6);
    chk("lb_13", ReadDataW, 32'hFFFF_FFDE);
    do_load(F3_BU, 32'h13, 5'd6);
    chk("lbu_13", ReadDataW, 32'h0000_00DE);
    do_load(F3_H, 32'h12, 5'd6);
    chk("lh_12", ReadDataW, 32'hFFFF_DEAD);
    do_load(F3_HU, 32'h10, 5'd6);
    chk("lhu_10", ReadDataW, 32'h0000_BEEF);

    do_store(F3_H, 32'h12, 32'h0000_1234);
    do_load(F3_W, 32'h10, 5'd7);
    chk("sh_merge", ReadDataW, 32'h1234_BEEF);
    do_store(F3_B, 32'h11, 32'h0000_0055);
    do_load(F3_W, 32'h10, 5'd7);
    chk("sb_merge", ReadDataW, 32'h1234_55EF);

    do_load(F3_W, 32'h12, 5'd8);
    chk("lw_mis_flag", {31'h0, MisalignW}, 32'h1);
    chk("lw_mis_data", ReadDataW, 32'h0);
    chk("lw_mis_regwrite", {31'h0, RegWriteW}, 32'h0);
    do_store(F3_W, 32'h11, 32'hCAFE_F00D);
    do_load(F3_W, 32'h10, 5'd9);
    chk("sw_mis_nowrite", ReadDataW, 32'h1234_55EF);

    // Stall with a store held in M, then release.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, RS_ALU, F3_W, 32'h20, 32'd5, 5'd0, 1'b1, 1'b0);
      chk("stall_hold", ReadDataW, 32'h1234_55EF);
    end
    do_store(F3_W, 32'h20, 32'd5);
    do_load(F3_W, 32'h20, 5'd10);
    chk("stall_store_once", ReadDataW, 32'd5);

    drive(1'b0, 1'b1, 1'b0, RS_ALU, F3_B, 32'h0000_0042, 32'h0, 5'd11, 1'b0, 1'b1);
    chk("flush_regwrite", {31'h0, RegWriteW}, 32'h0);
    chk("flush_rd", {27'h0, RdW}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, RS_ALU, F3_B, 32'h0000_0043, 32'h0, 5'd12, 1'b1, 1'b1);
    chk("flush_over_stall", {27'h0, RdW}, 32'h0);

    do_store(F3_W, 32'h400, 32'hA5A5_5A5A);
    do_load(F3_W, 32'h0, 5'd13);
    chk("wrap_alias", ReadDataW, 32'hA5A5_5A5A);

    do_store(F3_W, 32'h30, 32'h1111_1111);
    drive(1'b1, 1'b0, 1'b1, RS_ALU, F3_W, 32'h30, 32'h2222_2222, 5'd0, 1'b0, 1'b0);
    chk("rst_pc4", PCPlus4W, 32'h0);
    do_load(F3_W, 32'h30, 5'd14);
    chk("rst_no_write", ReadDataW, 32'h1111_1111);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        st, fl, r;
      kind = $urandom_range(0, 9);
      f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                         : ((kind < 4) ? 3'($urandom_range(0, 5))
                                                       : 3'($urandom_range(0, 2)));
      if (f3 == 3'd3 && $urandom_range(0, 1) == 0) f3 = F3_HU;
      addr = 32'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(acc_size(f3) - 1);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 99) == 0);
      if (kind < 4)
        drive(r, 1'b1, 1'b0, RS_MEM, f3, addr, 32'h0, 5'($urandom_range(1, 31)), st, fl);
      else if (kind < 7)
        drive(r, 1'b0, 1'b1, RS_ALU, f3, addr, $urandom, 5'd0, st, fl);
      else if (kind < 9)
        drive(r, 1'b1, 1'b0, RS_ALU, 3'($urandom_range(0, 7)), $urandom, $urandom,
              5'($urandom_range(0, 31)), st, fl);
      else
        drive(r, 1'b1, 1'b0, RS_PC4, 3'($urandom_range(0, 7)), $urandom, 32'h0,
              5'($urandom_range(0, 31)), st, fl);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
